mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Memory-stage controller that splits 32-bit loads/stores into byte-wide RAM
// accesses, assembling little-endian load words and stalling the pipeline meanwhile.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        stallreq,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_rd,
  output logic        ram_wr,
  input  logic [7:0]  ram_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_TAIL = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [1:0]  cnt_r;
  logic [1:0]  cnt_s;
  logic [31:0] base_r;
  logic        we_r;
  logic [3:0]  sel_r;
  logic [31:0] wdata_r;
  logic [1:0]  lane_s;

  // State and byte counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and byte counter sequencing.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_s = 2'd0;
        if (mem_ce) begin
          if (!mem_we) begin
            state_s = RD;
          end else if (mem_sel != 4'b0000) begin
            state_s = WR;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        cnt_s = cnt_r + 2'd1;
        if (cnt_r == 2'd3) begin
          state_s = RD_TAIL;
        end else begin
          state_s = RD;
        end
      end
      RD_TAIL: begin
        state_s = DONE;
      end
      WR: begin
        cnt_s = cnt_r + 2'd1;
        if (cnt_r == 2'd3) begin
          state_s = DONE;
        end else begin
          state_s = WR;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 2'd0;
      end
    endcase
  end

  // Request capture; the pipeline may change its inputs once we are busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r  <= 32'd0;
      we_r    <= 1'b0;
      sel_r   <= 4'd0;
      wdata_r <= 32'd0;
    end else if ((state_r == IDLE) && mem_ce) begin
      base_r  <= mem_addr & 32'hFFFF_FFFC;
      we_r    <= mem_we;
      sel_r   <= mem_sel;
      wdata_r <= mem_wdata;
    end else begin
      base_r  <= base_r;
      we_r    <= we_r;
      sel_r   <= sel_r;
      wdata_r <= wdata_r;
    end
  end

  // RAM data returns one cycle after its strobe, so it lands in the previous lane.
  assign lane_s = cnt_r - 2'd1;

  // Load word assembly; untouched outside reads so stores never disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata <= 32'd0;
    end else begin
      case (state_r)
        RD: begin
          if (cnt_r != 2'd0) begin
            mem_rdata[{lane_s, 3'b000} +: 8] <= ram_rdata;
          end else begin
            mem_rdata <= mem_rdata;
          end
        end
        RD_TAIL: begin
          mem_rdata[31:24] <= ram_rdata;
        end
        default: begin
          mem_rdata <= mem_rdata;
        end
      endcase
    end
  end

  // RAM strobes and stall request, forced quiet while reset is held.
  always_comb begin
    stallreq  = 1'b0;
    ram_rd    = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = 32'd0;
    ram_wdata = 8'd0;
    if (rst) begin
      stallreq = 1'b0;
      ram_rd   = 1'b0;
      ram_wr   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          stallreq = mem_ce;
        end
        RD: begin
          stallreq = 1'b1;
          ram_rd   = ~we_r;
          ram_addr = base_r + {30'd0, cnt_r};
        end
        RD_TAIL: begin
          stallreq = 1'b1;
        end
        WR: begin
          stallreq  = 1'b1;
          ram_addr  = base_r + {30'd0, cnt_r};
          ram_wdata = wdata_r[{cnt_r, 3'b000} +: 8];
          ram_wr    = we_r & sel_r[cnt_r];
        end
        DONE: begin
          stallreq = 1'b0;
        end
        default: begin
          stallreq = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a transaction-level model (phase counter per access plus
// byte-array memory image) is compared against the DUT outputs every cycle.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stallreq;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_rd;
  logic        ram_wr;
  logic [7:0]  ram_rdata;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stallreq(stallreq), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_rdata(ram_rdata)
  );

  int checks = 0;
  int errors = 0;

  // RAM as seen by the DUT (updated by its real writes) and the model's image
  logic [7:0] ram_mem [logic [31:0]];
  logic [7:0] mod_mem [logic [31:0]];

  // model state: access kind 0=load 1=store 2=empty store; phase = cycles since accept
  bit          m_busy = 1'b0;
  int          m_kind;
  int          m_ph;
  logic [31:0] m_base;
  logic [31:0] m_wdata;
  logic [3:0]  m_sel;
  logic [31:0] m_word;
  logic [31:0] m_rdata = 32'd0;

  // observed per-access statistics
  int          o_stall, o_rd, o_wr, o_wr_ph, o_first_rd_ph;
  logic [31:0] o_wr_addr;
  logic [7:0]  o_wr_data;
  logic [31:0] o_done_rdata;
  int          n_accept = 0;
  int          n_done = 0;
  int          tot_rd = 0;
  int          tot_stall = 0;

  function automatic logic [7:0] seed_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hC3;
  endfunction

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return seed_byte(a);
  endfunction

  function automatic logic [7:0] mod_byte(input logic [31:0] a);
    if (mod_mem.exists(a)) return mod_mem[a];
    return seed_byte(a);
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk32(name, {31'd0, act}, {31'd0, exp});
  endtask

  // One clock cycle: compare at the falling edge, act as RAM at the rising edge.
  task automatic cycle();
    bit          rd_pend;
    logic [31:0] rd_a;
    int          cph;
    bit          last;
    logic [7:0]  eb;
    @(negedge clk);
    rd_pend = ram_rd;
    rd_a    = ram_addr;
    cph     = m_busy ? m_ph : 0;
    if (ram_wr) ram_mem[ram_addr] = ram_wdata;
    chk1("rd_wr_excl", ram_rd & ram_wr, 1'b0);
    if (rst) begin
      chk1("rst_stall", stallreq, 1'b0);
      chk1("rst_rd", ram_rd, 1'b0);
      chk1("rst_wr", ram_wr, 1'b0);
      m_busy  = 1'b0;
      m_rdata = 32'd0;
    end else if (!m_busy) begin
      chk1("idle_stall", stallreq, mem_ce);
      chk1("idle_rd", ram_rd, 1'b0);
      chk1("idle_wr", ram_wr, 1'b0);
      chk32("idle_addr", ram_addr, 32'd0);
      chk32("idle_wdata", {24'd0, ram_wdata}, 32'd0);
      chk32("idle_rdata", mem_rdata, m_rdata);
      if (mem_ce) begin
        m_busy  = 1'b1;
        m_ph    = 1;
        m_base  = mem_addr & 32'hFFFF_FFFC;
        m_sel   = mem_sel;
        m_wdata = mem_wdata;
        m_kind  = !mem_we ? 0 : ((mem_sel != 4'd0) ? 1 : 2);
        m_word  = {mod_byte(m_base + 32'd3), mod_byte(m_base + 32'd2),
                   mod_byte(m_base + 32'd1), mod_byte(m_base)};
        n_accept++;
        o_stall = 0; o_rd = 0; o_wr = 0; o_wr_ph = -1; o_first_rd_ph = -1;
        o_wr_addr = 32'd0; o_wr_data = 8'd0;
      end
    end else begin
      last = (m_kind == 0 && m_ph == 6) || (m_kind == 1 && m_ph == 5) ||
             (m_kind == 2 && m_ph == 1);
      if (last) begin
        if (m_kind == 0) m_rdata = m_word;
        chk1("done_stall", stallreq, 1'b0);
        chk1("done_rd", ram_rd, 1'b0);
        chk1("done_wr", ram_wr, 1'b0);
        chk32("done_addr", ram_addr, 32'd0);
        chk32("done_rdata", mem_rdata, m_rdata);
        o_done_rdata = mem_rdata;
        m_busy = 1'b0;
        n_done++;
      end else if (m_kind == 0) begin
        chk1("ld_stall", stallreq, 1'b1);
        chk1("ld_wr", ram_wr, 1'b0);
        chk1("ld_rd", ram_rd, m_ph <= 4);
        chk32("ld_addr", ram_addr, (m_ph <= 4) ? m_base + 32'(m_ph - 1) : 32'd0);
        if (m_ph == 1) chk32("ld_rdata_hold", mem_rdata, m_rdata);
      end else begin
        eb = m_wdata[8*(m_ph-1) +: 8];
        chk1("st_stall", stallreq, 1'b1);
        chk1("st_rd", ram_rd, 1'b0);
        chk1("st_wr", ram_wr, m_sel[m_ph-1]);
        chk32("st_addr", ram_addr, m_base + 32'(m_ph - 1));
        chk32("st_wdata", {24'd0, ram_wdata}, {24'd0, eb});
        chk32("st_rdata_hold", mem_rdata, m_rdata);
        if (m_sel[m_ph-1]) mod_mem[m_base + 32'(m_ph - 1)] = eb;
      end
      m_ph++;
    end
    if (!rst) begin
      if (stallreq) begin o_stall++; tot_stall++; end
      if (ram_rd) begin
        o_rd++; tot_rd++;
        if (o_first_rd_ph < 0) o_first_rd_ph = cph;
      end
      if (ram_wr) begin
        o_wr++; o_wr_ph = cph; o_wr_addr = ram_addr; o_wr_data = ram_wdata;
      end
    end
    @(posedge clk);
    #1;
    ram_rdata = rd_pend ? ram_byte(rd_a) : 8'($urandom);
  endtask

  task automatic scramble_req();
    mem_we    = 1'($urandom);
    mem_sel   = 4'($urandom);
    mem_addr  = $urandom;
    mem_wdata = $urandom;
  endtask

  // Issue one request, then scramble the inputs until the model sees completion.
  task automatic xact(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                      input logic [31:0] wdata);
    mem_ce = 1'b1; mem_we = we; mem_sel = sel; mem_addr = addr; mem_wdata = wdata;
    cycle();
    mem_ce = 1'b0;
    for (int i = 0; i < 12 && m_busy; i++) begin
      scramble_req();
      cycle();
    end
  endtask

  initial begin
    int snap_rd, snap_stall, snap_acc, snap_done;
    rst = 1'b1; mem_ce = 1'b0; mem_we = 1'b0; mem_sel = 4'd0;
    mem_addr = 32'd0; mem_wdata = 32'd0; ram_rdata = 8'd0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk32("reset_rdata", mem_rdata, 32'd0);
    chk1("reset_stall", stallreq, 1'b0);

    // load of 0x102 from bytes 11,22,33,44
    for (int k = 0; k < 4; k++) begin
      ram_mem[32'h100 + 32'(k)] = 8'(8'h11 * (k + 1));
      mod_mem[32'h100 + 32'(k)] = 8'(8'h11 * (k + 1));
    end
    xact(1'b0, 4'hF, 32'h102, 32'h0);
    chk32("ld_word", o_done_rdata, 32'h4433_2211);
    chk32("ld_rd_count", 32'(o_rd), 32'd4);
    chk32("ld_stall_cycles", 32'(o_stall), 32'd6);
    chk32("ld_first_rd_cycle", 32'(o_first_rd_ph), 32'd1);

    // byte store to 0x201
    xact(1'b1, 4'b0010, 32'h201, 32'hABAB_ABAB);
    chk32("sb_wr_count", 32'(o_wr), 32'd1);
    chk32("sb_wr_addr", o_wr_addr, 32'h201);
    chk32("sb_wr_data", {24'd0, o_wr_data}, 32'hAB);
    chk32("sb_wr_cycle", 32'(o_wr_ph), 32'd2);
    chk32("sb_stall_cycles", 32'(o_stall), 32'd5);
    chk32("sb_rdata_kept", mem_rdata, 32'h4433_2211);

    // word store then load back
    xact(1'b1, 4'hF, 32'h300, 32'hDEAD_BEEF);
    chk32("sw_wr_count", 32'(o_wr), 32'd4);
    chk32("sw_b0", {24'd0, ram_byte(32'h300)}, 32'hEF);
    chk32("sw_b1", {24'd0, ram_byte(32'h301)}, 32'hBE);
    chk32("sw_b2", {24'd0, ram_byte(32'h302)}, 32'hAD);
    chk32("sw_b3", {24'd0, ram_byte(32'h303)}, 32'hDE);
    xact(1'b0, 4'h0, 32'h300, 32'h0);
    chk32("sw_readback", o_done_rdata, 32'hDEAD_BEEF);

    // empty store
    xact(1'b1, 4'b0000, 32'h310, 32'h1234_5678);
    chk32("s0_wr_count", 32'(o_wr), 32'd0);
    chk32("s0_stall_cycles", 32'(o_stall), 32'd1);

    // back-to-back loads with mem_ce held high
    snap_rd = tot_rd; snap_stall = tot_stall; snap_acc = n_accept; snap_done = n_done;
    mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h100;
    for (int i = 0; i < 30 && n_done < snap_done + 2; i++) cycle();
    mem_ce = 1'b0;
    chk32("b2b_accepts", 32'(n_accept - snap_acc), 32'd2);
    chk32("b2b_rd_count", 32'(tot_rd - snap_rd), 32'd8);
    chk32("b2b_stall_cycles", 32'(tot_stall - snap_stall), 32'd12);
    chk32("b2b_word", o_done_rdata, 32'h4433_2211);

    // reset in cycle 2 of a load
    xact(1'b1, 4'hF, 32'h100, 32'h0000_0000);
    xact(1'b1, 4'hF, 32'h100, 32'h0403_0201);
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    cycle();
    mem_ce = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    snap_rd = tot_rd;
    for (int i = 0; i < 3; i++) cycle();
    chk32("rst_mid_rd", 32'(tot_rd - snap_rd), 32'd0);
    chk32("rst_mid_rdata", mem_rdata, 32'd0);
    chk1("rst_mid_stall", stallreq, 1'b0);
    xact(1'b0, 4'hF, 32'h100, 32'h0);
    chk32("post_rst_load", o_done_rdata, 32'h0403_0201);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      mem_ce    = ($urandom_range(0, 2) == 0);
      mem_we    = 1'($urandom);
      mem_sel   = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
      mem_addr  = 32'h400 + 32'($urandom_range(0, 63));
      mem_wdata = $urandom;
      cycle();
    end
    rst = 1'b0; mem_ce = 1'b0;
    for (int i = 0; i < 12 && m_busy; i++) cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
